// File: rtl/drum_dot_acc.sv
// drum_dot_acc: saturating dot-product accumulator fed by a DRUM multiplier product stream
module drum_dot_acc #(
   parameter int PW    = 16,
   parameter int ACC_W = 20
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             start,
   input  logic [3:0]       len,
   input  logic             p_valid,
   output logic             p_ready,
   input  logic [PW-1:0]    p_data,
   output logic             res_valid,
   input  logic             res_ready,
   output logic [ACC_W-1:0] res_data,
   output logic             res_ovf,
   output logic             busy
);
   typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;
   localparam logic [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};
   state_t           state_q;
   logic [ACC_W-1:0] acc_q, acc_d;
   logic [3:0]       cnt_q, len_q;
   logic             ovf_q;
   logic [ACC_W:0]   sum;
   logic             sum_ovf, hs, last;
   // one guard bit above the accumulator exposes overflow; clamp toward the sign of the true sum
   always_comb begin
      sum     = {acc_q[ACC_W-1], acc_q} + {{(ACC_W+1-PW){p_data[PW-1]}}, p_data};
      sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];
      acc_d   = !sum_ovf ? sum[ACC_W-1:0] : (sum[ACC_W] ? SAT_MIN : SAT_MAX);
      hs      = (state_q == ACC) && p_valid;
      last    = cnt_q == len_q - 4'd1;
   end
   // job FSM; clear outranks start and handshakes, reset discards any job in flight
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         len_q   <= '0;
         ovf_q   <= 1'b0;
      end else if (clear) begin
         state_q <= IDLE;
         acc_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               len_q   <= len;
               acc_q   <= '0;
               cnt_q   <= '0;
               ovf_q   <= 1'b0;
               state_q <= (len == 4'd0) ? DONE : ACC;
            end
            ACC: if (hs) begin
               acc_q   <= acc_d;
               ovf_q   <= ovf_q | sum_ovf;
               cnt_q   <= cnt_q + 4'd1;
               state_q <= last ? DONE : ACC;
            end
            DONE: if (res_ready) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end
   assign p_ready   = state_q == ACC;
   assign res_valid = state_q == DONE;
   assign busy      = state_q != IDLE;
   assign res_data  = acc_q;
   assign res_ovf   = ovf_q;
endmodule

// File: tb/tb_drum_dot_acc.sv
// tb_drum_dot_acc: scoreboard bench for drum_dot_acc built with a 17-bit accumulator
module tb_drum_dot_acc;
   localparam int PW = 16;
   localparam int ACC_W = 17;
   localparam longint MAXV = (longint'(1) <<< (ACC_W-1)) - 1;
   localparam longint MINV = -(longint'(1) <<< (ACC_W-1));
   logic clk = 0, rst = 1, clear = 0, start = 0, p_valid = 0, res_ready = 0;
   logic [3:0] len = 0;
   logic [PW-1:0] p_data = 0;
   logic p_ready, res_valid, res_ovf, busy;
   logic [ACC_W-1:0] res_data;
   logic [ACC_W:0] sb[$];
   logic [ACC_W:0] exp_r;
   longint m_acc;
   logic m_ovf;
   int vectors = 0, errors = 0;

   drum_dot_acc #(.PW(PW), .ACC_W(ACC_W)) dut (
      .clk(clk), .rst(rst), .clear(clear), .start(start), .len(len),
      .p_valid(p_valid), .p_ready(p_ready), .p_data(p_data),
      .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
      .res_ovf(res_ovf), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic do_start(input int n);
      start = 1; len = 4'(n);
      m_acc = 0; m_ovf = 0;
      @(negedge clk);
      start = 0;
   endtask

   task automatic send_prod(input int v);
      logic [PW-1:0] pv;
      p_valid = 1; pv = PW'(v); p_data = pv;
      m_acc = m_acc + v;
      if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1; end
      else if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1; end
      @(negedge clk);
      p_valid = 0;
   endtask

   task automatic push_exp();
      logic [63:0] a;
      a = 64'(m_acc);
      sb.push_back({m_ovf, a[ACC_W-1:0]});
   endtask

   task automatic wait_res(output bit ok);
      ok = 0;
      for (int i = 0; i < 50; i++) begin
         if (res_valid) begin ok = 1; break; end
         @(negedge clk);
      end
      if (!ok) begin
         vectors++; errors++;
         $display("FAIL wait_res_valid timeout got res_valid=%0b need 1", res_valid);
      end
   endtask

   task automatic take();
      res_ready = 1;
      @(negedge clk);
      res_ready = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      repeat (2) @(negedge clk);
      vectors++;
      if ({p_ready, res_valid, busy, res_ovf, res_data} !== '0) begin
         errors++;
         $display("FAIL reset_outputs got p_ready=%0b res_valid=%0b busy=%0b ovf=%0b data=%0d need all 0", p_ready, res_valid, busy, res_ovf, res_data);
      end
      rst = 0;
      @(negedge clk);
      vectors++;
      if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %0b need 0", busy); end
   endtask

   task automatic test_basic();
      do_start(3);
      vectors++;
      if (p_ready !== 1'b1) begin errors++; $display("FAIL basic_p_ready got %0b need 1", p_ready); end
      send_prod(100);
      send_prod(-30);
      push_exp_placeholder();
   endtask

   task automatic push_exp_placeholder();
      vectors++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid got %0b need 0", res_valid); end
      send_prod(7);
      push_exp();
      vectors++;
      if (res_valid !== 1'b1) begin errors++; $display("FAIL basic_latency res_valid got %0b need 1", res_valid); end
      exp_r = sb.pop_front();
      vectors++;
      if ({res_ovf, res_data} !== exp_r) begin
         errors++;
         $display("FAIL basic_result got ovf=%0b data=%0d need ovf=%0b data=%0d", res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0]));
      end
      take();
      vectors++;
      if ({res_valid, busy} !== 2'b00) begin errors++; $display("FAIL basic_to_idle got valid=%0b busy=%0b need 0 0", res_valid, busy); end
   endtask

   task automatic test_gaps();
      bit ok;
      do_start(2);
      send_prod(500);
      start = 1; len = 4'd7;
      @(negedge clk);
      start = 0;
      @(negedge clk);
      vectors++;
      if ({busy, p_ready, res_valid} !== 3'b110) begin errors++; $display("FAIL gaps_hold got busy=%0b p_ready=%0b valid=%0b need 1 1 0", busy, p_ready, res_valid); end
      send_prod(-1234);
      push_exp();
      wait_res(ok);
      if (ok) begin
         exp_r = sb.pop_front();
         for (int i = 0; i < 5; i++) begin
            vectors++;
            if ({res_valid, busy, p_ready, res_ovf, res_data} !== {3'b110, exp_r}) begin
               errors++;
               $display("FAIL gaps_stable cyc %0d got valid=%0b busy=%0b p_ready=%0b ovf=%0b data=%0d need 1 1 0 ovf=%0b data=%0d", i, res_valid, busy, p_ready, res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0]));
            end
            start = (i == 2); len = 4'd5;
            @(negedge clk);
         end
         start = 0;
         take();
         vectors++;
         if ({res_valid, busy, res_data} !== {2'b00, exp_r[ACC_W-1:0]}) begin
            errors++;
            $display("FAIL gaps_after_take got valid=%0b busy=%0b data=%0d need 0 0 data=%0d", res_valid, busy, $signed(res_data), $signed(exp_r[ACC_W-1:0]));
         end
      end
   endtask

   task automatic test_sat();
      bit ok;
      int pos[5];
      pos = '{32767, 32767, 32767, -32768, -1};
      do_start(4);
      repeat (4) send_prod(32767);
      push_exp();
      wait_res(ok);
      if (ok) begin
         exp_r = sb.pop_front();
         vectors++;
         if ({res_ovf, res_data} !== exp_r) begin errors++; $display("FAIL sat_pos got ovf=%0b data=%0d need ovf=%0b data=%0d", res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0])); end
      end
      take();
      do_start(4);
      repeat (4) send_prod(-32768);
      push_exp();
      wait_res(ok);
      if (ok) begin
         exp_r = sb.pop_front();
         vectors++;
         if ({res_ovf, res_data} !== exp_r) begin errors++; $display("FAIL sat_neg got ovf=%0b data=%0d need ovf=%0b data=%0d", res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0])); end
      end
      take();
      do_start(5);
      foreach (pos[i]) send_prod(pos[i]);
      push_exp();
      wait_res(ok);
      if (ok) begin
         exp_r = sb.pop_front();
         vectors++;
         if ({res_ovf, res_data} !== exp_r) begin errors++; $display("FAIL sat_continue got ovf=%0b data=%0d need ovf=%0b data=%0d", res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0])); end
      end
      take();
   endtask

   task automatic test_len0();
      do_start(0);
      push_exp();
      exp_r = sb.pop_front();
      vectors++;
      if ({res_valid, res_ovf, res_data} !== {1'b1, exp_r}) begin
         errors++;
         $display("FAIL len0_done got valid=%0b ovf=%0b data=%0d need 1 0 0", res_valid, res_ovf, $signed(res_data));
      end
      take();
      vectors++;
      if (res_valid !== 1'b0) begin errors++; $display("FAIL len0_idle got valid=%0b need 0", res_valid); end
   endtask

   task automatic test_clear();
      bit ok;
      do_start(3);
      send_prod(1000);
      clear = 1; p_valid = 1; p_data = 16'd50;
      @(negedge clk);
      clear = 0; p_valid = 0;
      vectors++;
      if ({busy, p_ready, res_valid, res_ovf, res_data} !== '0) begin
         errors++;
         $display("FAIL clear_abort got busy=%0b p_ready=%0b valid=%0b ovf=%0b data=%0d need all 0", busy, p_ready, res_valid, res_ovf, $signed(res_data));
      end
      start = 1; clear = 1; len = 4'd2;
      @(negedge clk);
      start = 0; clear = 0;
      repeat (2) @(negedge clk);
      vectors++;
      if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL clear_start_drop got busy=%0b valid=%0b need 0 0", busy, res_valid); end
      do_start(3);
      send_prod(-20000);
      send_prod(123);
      send_prod(4);
      push_exp();
      wait_res(ok);
      if (ok) begin
         exp_r = sb.pop_front();
         vectors++;
         if ({res_ovf, res_data} !== exp_r) begin errors++; $display("FAIL clear_new_job got ovf=%0b data=%0d need ovf=%0b data=%0d", res_ovf, $signed(res_data), exp_r[ACC_W], $signed(exp_r[ACC_W-1:0])); end
      end
      take();
   endtask

   task automatic test_async_rst();
      do_start(1);
      send_prod(9);
      vectors++;
      if ({res_valid, res_data} !== {1'b1, 17'd9}) begin errors++; $display("FAIL arst_pre got valid=%0b data=%0d need 1 9", res_valid, $signed(res_data)); end
      #2 rst = 1;
      #1;
      vectors++;
      if ({p_ready, res_valid, busy, res_ovf, res_data} !== '0) begin
         errors++;
         $display("FAIL arst_immediate got p_ready=%0b valid=%0b busy=%0b ovf=%0b data=%0d need all 0", p_ready, res_valid, busy, res_ovf, $signed(res_data));
      end
      #1 rst = 0;
      @(negedge clk);
      vectors++;
      if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL arst_release got busy=%0b valid=%0b need 0 0", busy, res_valid); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_gaps();
      test_sat();
      test_len0();
      test_clear();
      test_async_rst();
      vectors++;
      if (sb.size() != 0) begin errors++; $display("FAIL scoreboard_left got %0d need 0", sb.size()); end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end
endmodule
